// File: rtl/bcd_digit_counter.sv
// Multi-digit synchronous BCD up-counter with prescaler, feeding the 7-segment decoders.
// Define BCD_COUNTER_SATURATE_EN to hold at all-9s instead of rolling over.
module bcd_digit_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  step,
    output logic                  wrap
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc;
    logic             tick;
    logic             all_nines;

    // Digits above 9 are not valid BCD; load them as 0.
    function automatic logic [4*DIGITS-1:0] bcd_sanitize(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                r[4*i +: 4] = 4'd0;
        end
        return r;
    endfunction

    function automatic logic bcd_is_max(input logic [4*DIGITS-1:0] v);
        logic m;
        m = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9)
                m = 1'b0;
        end
        return m;
    endfunction

    // Ripple a decimal carry from digit 0 upward.
    function automatic logic [4*DIGITS-1:0] bcd_incr(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick      = en && (psc == PSC_LAST);
    assign all_nines = bcd_is_max(count);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            psc   <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= bcd_sanitize(load_value);
            psc   <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            step <= tick;
            wrap <= 1'b0;
            if (en)
                psc <= tick ? '0 : psc + 1'b1;
            if (tick) begin
`ifdef BCD_COUNTER_SATURATE_EN
                if (!all_nines)
                    count <= bcd_incr(count);
`else
                count <= bcd_incr(count);
                wrap  <= all_nines;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Randomized scoreboard bench for bcd_digit_counter against a decimal-integer reference model.
module tb_bcd_digit_counter;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int W        = 4 * DIGITS;
    localparam int MAXV     = 99;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] count;
    logic         step;
    logic         wrap;

    bcd_digit_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .load_value(load_value), .count(count), .step(step), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         stp;
        logic         wrp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: count held as a plain decimal integer.
    int m_val = 0;
    int m_psc = 0;
    bit m_step = 0;
    bit m_wrap = 0;

    function automatic int decode_load(input logic [W-1:0] lv);
        int v, pw, d;
        v  = 0;
        pw = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((lv >> (4 * i)) & 'hF);
            if (d > 9) d = 0;
            v  += d * pw;
            pw *= 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int pw;
        r  = '0;
        pw = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / pw) % 10);
            pw *= 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic cyc(input bit r, input bit e, input bit l, input logic [W-1:0] lv);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; load = l; load_value = lv;
        m_step = 0;
        m_wrap = 0;
        if (r) begin
            m_val = 0;
            m_psc = 0;
        end else if (l) begin
            m_val = decode_load(lv);
            m_psc = 0;
        end else if (e) begin
            if (m_psc == PRESCALE - 1) begin
                m_psc  = 0;
                m_step = 1;
                if (m_val == MAXV) begin
`ifndef BCD_COUNTER_SATURATE_EN
                    m_val  = 0;
                    m_wrap = 1;
`endif
                end else begin
                    m_val++;
                end
            end else begin
                m_psc++;
            end
        end
        x.cnt = to_bcd(m_val);
        x.stp = m_step;
        x.wrp = m_wrap;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("count", 32'(count), 32'(x.cnt));
                check("step",  32'(step),  32'(x.stp));
                check("wrap",  32'(wrap),  32'(x.wrp));
            end
        end
    end

    initial begin : stim
        logic [W-1:0] lv;
        bit r, e, l;
        repeat (2) cyc(1, 0, 0, '0);
        // Free run: four steps in sixteen enabled cycles.
        repeat (16) cyc(0, 1, 0, '0);
        // Enable gaps hold the prescaler.
        cyc(1, 0, 0, '0);
        repeat (2) cyc(0, 1, 0, '0);
        repeat (5) cyc(0, 0, 0, '0);
        repeat (2) cyc(0, 1, 0, '0);
        // Roll over (or saturate) from all-9s.
        cyc(0, 0, 1, 8'h98);
        repeat (12) cyc(0, 1, 0, '0);
        // Load coinciding with a step edge, with an invalid low digit.
        while (m_psc != PRESCALE - 1) cyc(0, 1, 0, '0);
        cyc(0, 1, 1, 8'h3F);
        repeat (6) cyc(0, 1, 0, '0);
        // Reset mid-count.
        cyc(0, 0, 1, 8'h57);
        repeat (2) cyc(0, 1, 0, '0);
        cyc(1, 1, 0, '0);
        repeat (6) cyc(0, 1, 0, '0);
        // Saturation / wrap from 0x99.
        cyc(0, 0, 1, 8'h99);
        repeat (10) cyc(0, 1, 0, '0);
        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 24) == 0);
            lv = W'($urandom);
            if ($urandom_range(0, 3) == 0) lv = 8'h99;
            cyc(r, e, l, lv);
        end
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
